// File: rtl/conc_stim_player.sv
`default_nettype none
// ============================================================================
// Module   : conc_stim_player
// Purpose  : Opcode stimulus sequencer. A host loads a short opcode program
//            into a small RAM and starts playback; one opcode is issued per
//            clock as {obs, stbi, x_in}. Single-shot and looping playback,
//            halt, and a saturating issued-opcode counter.
// Revision : 1.0 - initial release
// ============================================================================
module conc_stim_player #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   input  logic          halt,
   input  logic          loop_en,
   output logic [5:0]    x_in,
   output logic          stbi,
   output logic          obs,
   output logic [AW:0]   pc,
   output logic          busy,
   output logic          done,
   output logic [15:0]   issue_cnt
);

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [7:0]  ram [DEPTH];
   logic [7:0]  op, op_nx;
   logic [AW:0] len, len_nx;
   logic [AW:0] pc_nx;
   logic        loop_q, loop_nx;
   logic [15:0] cnt_nx;
   logic [15:0] cnt_inc;
   logic [7:0]  ram_pc;
   logic [7:0]  ram_0;
   logic        wr_ok;

   // Writes are only taken while not playing and only for in-range addresses.
   assign wr_ok   = wr_en && (state != S_RUN) && ({1'b0, wr_addr} < DEPTH_W);

   // Reads use the pre-edge contents, so a write coinciding with a start
   // does not affect the opcode issued for entry 0.
   assign ram_pc  = ram[pc[AW-1:0]];
   assign ram_0   = ram[0];
   assign cnt_inc = (issue_cnt == 16'hFFFF) ? issue_cnt : issue_cnt + 16'd1;

   // Opcode RAM: not reset so a program survives a reset pulse.
   always_ff @(posedge clock) begin
      if (wr_ok) begin
         ram[wr_addr] <= wr_data;
      end
   end

   // Next-state, next-opcode, pc and counter decisions.
   always_comb begin
      state_nx = state;
      op_nx    = op;
      len_nx   = len;
      loop_nx  = loop_q;
      pc_nx    = pc;
      cnt_nx   = issue_cnt;
      case (state)
         S_IDLE, S_DONE: begin
            if (halt) begin
               // Halt beats a simultaneous start; from DONE it rewinds pc.
               state_nx = S_IDLE;
               pc_nx    = '0;
               op_nx    = '0;
            end else if (start) begin
               len_nx  = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
               loop_nx = loop_en;
               if (len_nx == '0) begin
                  state_nx = S_DONE;
                  op_nx    = '0;
                  pc_nx    = '0;
                  cnt_nx   = 16'd0;
               end else begin
                  state_nx = S_RUN;
                  op_nx    = ram_0;
                  pc_nx    = (AW + 1)'(1);
                  cnt_nx   = 16'd1;
               end
            end
         end
         S_RUN: begin
            if (halt) begin
               state_nx = S_IDLE;
               op_nx    = '0;
               pc_nx    = '0;
            end else if (pc < len) begin
               op_nx  = ram_pc;
               pc_nx  = pc + (AW + 1)'(1);
               cnt_nx = cnt_inc;
            end else if (loop_q) begin
               // Wrap straight back to entry 0 with no idle bubble.
               op_nx  = ram_0;
               pc_nx  = (AW + 1)'(1);
               cnt_nx = cnt_inc;
            end else begin
               state_nx = S_DONE;
               op_nx    = '0;
            end
         end
         default: begin
            state_nx = S_IDLE;
            op_nx    = '0;
            pc_nx    = '0;
         end
      endcase
   end

   // State and registered outputs; reset clears them asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         op        <= '0;
         len       <= '0;
         loop_q    <= 1'b0;
         pc        <= '0;
         issue_cnt <= 16'd0;
      end else begin
         state     <= state_nx;
         op        <= op_nx;
         len       <= len_nx;
         loop_q    <= loop_nx;
         pc        <= pc_nx;
         issue_cnt <= cnt_nx;
      end
   end

   assign obs  = op[7];
   assign stbi = op[6];
   assign x_in = op[5:0];
   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conc_stim_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_conc_stim_player
// Purpose  : Table-driven check of conc_stim_player plus hand-written
//            sequences for full-depth play, out-of-range write and async
//            reset mid-run. Built with AW=5 so out-of-range addresses exist.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conc_stim_player;

   localparam int DEPTH = 16;
   localparam int AW    = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [AW:0]   prog_len;
   logic          start, halt, loop_en;
   logic [5:0]    x_in;
   logic          stbi, obs;
   logic [AW:0]   pc;
   logic          busy, done;
   logic [15:0]   issue_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   conc_stim_player #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .prog_len  (prog_len),
      .start     (start),
      .halt      (halt),
      .loop_en   (loop_en),
      .x_in      (x_in),
      .stbi      (stbi),
      .obs       (obs),
      .pc        (pc),
      .busy      (busy),
      .done      (done),
      .issue_cnt (issue_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic        st, hl, lp, we;
      logic [4:0]  wa;
      logic [7:0]  wd;
      logic [5:0]  pl;
      logic [7:0]  e_op;
      logic        e_busy, e_done;
      logic [5:0]  e_pc;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(string nm, logic st, logic hl, logic lp, logic we,
                               logic [4:0] wa, logic [7:0] wd, logic [5:0] pl,
                               logic [7:0] eop, logic eb, logic ed,
                               logic [5:0] epc, logic [15:0] ecnt);
      vec_t v;
      v.name = nm; v.st = st; v.hl = hl; v.lp = lp; v.we = we;
      v.wa = wa; v.wd = wd; v.pl = pl;
      v.e_op = eop; v.e_busy = eb; v.e_done = ed; v.e_pc = epc; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic drive(logic st, logic hl, logic lp, logic we,
                        logic [4:0] wa, logic [7:0] wd, logic [5:0] pl);
      start = st; halt = hl; loop_en = lp; wr_en = we;
      wr_addr = wa; wr_data = wd; prog_len = pl;
   endtask

   task automatic check(string nm, logic [7:0] eop, logic eb, logic ed,
                        logic [5:0] epc, logic [15:0] ecnt);
      logic [7:0] aop;
      aop = {obs, stbi, x_in};
      n_tests++;
      if ({aop, busy, done, pc, issue_cnt} !== {eop, eb, ed, epc, ecnt}) begin
         n_fail++;
         $display("FAIL %s: got op=%h busy=%b done=%b pc=%0d cnt=%0d, expected op=%h busy=%b done=%b pc=%0d cnt=%0d",
                  nm, aop, busy, done, pc, issue_cnt, eop, eb, ed, epc, ecnt);
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] seq16 [16];

      // name, start, halt, loop, wr_en, addr, data, prog_len | op, busy, done, pc, cnt
      tbl.push_back(mk("wr0",         0,0,0,1, 5'd0, 8'h85, 6'd0,  8'h00,0,0,6'd0,16'd0));
      tbl.push_back(mk("wr1",         0,0,0,1, 5'd1, 8'h4A, 6'd0,  8'h00,0,0,6'd0,16'd0));
      tbl.push_back(mk("wr2",         0,0,0,1, 5'd2, 8'h3F, 6'd0,  8'h00,0,0,6'd0,16'd0));
      tbl.push_back(mk("ss_op0",      1,0,0,0, 5'd0, 8'h00, 6'd3,  8'h85,1,0,6'd1,16'd1));
      tbl.push_back(mk("ss_op1",      0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h4A,1,0,6'd2,16'd2));
      tbl.push_back(mk("ss_op2",      0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h3F,1,0,6'd3,16'd3));
      tbl.push_back(mk("ss_done",     0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h00,0,1,6'd3,16'd3));
      tbl.push_back(mk("lp_1",        1,0,1,0, 5'd0, 8'h00, 6'd3,  8'h85,1,0,6'd1,16'd1));
      tbl.push_back(mk("lp_2",        0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h4A,1,0,6'd2,16'd2));
      tbl.push_back(mk("lp_3",        0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h3F,1,0,6'd3,16'd3));
      tbl.push_back(mk("lp_4_wrap",   0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h85,1,0,6'd1,16'd4));
      tbl.push_back(mk("lp_5_startig",1,0,0,0, 5'd0, 8'h00, 6'd0,  8'h4A,1,0,6'd2,16'd5));
      tbl.push_back(mk("lp_6",        0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h3F,1,0,6'd3,16'd6));
      tbl.push_back(mk("lp_7",        0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h85,1,0,6'd1,16'd7));
      tbl.push_back(mk("lp_halt",     0,1,0,0, 5'd0, 8'h00, 6'd0,  8'h00,0,0,6'd0,16'd7));
      tbl.push_back(mk("start_halt",  1,1,0,0, 5'd0, 8'h00, 6'd3,  8'h00,0,0,6'd0,16'd7));
      tbl.push_back(mk("len0",        1,0,0,0, 5'd0, 8'h00, 6'd0,  8'h00,0,1,6'd0,16'd0));
      tbl.push_back(mk("done_halt",   0,1,0,0, 5'd0, 8'h00, 6'd0,  8'h00,0,0,6'd0,16'd0));
      tbl.push_back(mk("wb_op0",      1,0,0,0, 5'd0, 8'h00, 6'd3,  8'h85,1,0,6'd1,16'd1));
      tbl.push_back(mk("wb_op1",      0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h4A,1,0,6'd2,16'd2));
      tbl.push_back(mk("wb_runwrite", 0,0,0,1, 5'd1, 8'hFF, 6'd0,  8'h3F,1,0,6'd3,16'd3));
      tbl.push_back(mk("wb_done",     0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h00,0,1,6'd3,16'd3));
      tbl.push_back(mk("wb_replay0",  1,0,0,0, 5'd0, 8'h00, 6'd3,  8'h85,1,0,6'd1,16'd1));
      tbl.push_back(mk("wb_replay1",  0,0,0,0, 5'd0, 8'h00, 6'd0,  8'h4A,1,0,6'd2,16'd2));
      tbl.push_back(mk("halt_2nd",    0,1,0,0, 5'd0, 8'h00, 6'd0,  8'h00,0,0,6'd0,16'd2));

      reset = 1'b1;
      drive(0,0,0,0,5'd0,8'h00,6'd0);
      #12;
      check("reset_state", 8'h00, 0, 0, 6'd0, 16'd0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].st, tbl[i].hl, tbl[i].lp, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].pl);
         @(negedge clock);
         check(tbl[i].name, tbl[i].e_op, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_pc, tbl[i].e_cnt);
      end

      // Fill the rest of the RAM, then try an out-of-range write.
      for (int a = 3; a < DEPTH; a++) begin
         drive(0,0,0,1,5'(a),8'(8'h10 + a),6'd0);
         @(negedge clock);
      end
      check("fill_idle", 8'h00, 0, 0, 6'd0, 16'd2);
      drive(0,0,0,1,5'd20,8'h11,6'd0);
      @(negedge clock);

      // Oversized program length is clamped to the RAM depth.
      seq16[0] = 8'h85; seq16[1] = 8'h4A; seq16[2] = 8'h3F;
      for (int a = 3; a < DEPTH; a++) seq16[a] = 8'(8'h10 + a);
      drive(1,0,0,0,5'd0,8'h00,6'd31);
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clock);
         check($sformatf("len31_op%0d", k), seq16[k], 1, 0, 6'(k + 1), 16'(k + 1));
         drive(0,0,0,0,5'd0,8'h00,6'd0);
      end
      @(negedge clock);
      check("len31_done", 8'h00, 0, 1, 6'd16, 16'd16);

      // Write together with a start: ram[0] is issued with its old value.
      drive(1,0,1,1,5'd0,8'hC1,6'd3);
      @(negedge clock);
      check("startwr_op0", 8'h85, 1, 0, 6'd1, 16'd1);
      drive(0,0,0,0,5'd0,8'h00,6'd0);
      @(negedge clock);
      check("pre_reset", 8'h4A, 1, 0, 6'd2, 16'd2);

      // Reset between edges clears outputs without a clock edge.
      #2 reset = 1'b1;
      #1 check("async_reset", 8'h00, 0, 0, 6'd0, 16'd0);
      @(negedge clock);
      reset = 1'b0;
      drive(1,0,0,0,5'd0,8'h00,6'd3);
      @(negedge clock);
      check("post_reset_op0", 8'hC1, 1, 0, 6'd1, 16'd1);
      drive(0,0,0,0,5'd0,8'h00,6'd0);
      @(negedge clock);
      check("post_reset_op1", 8'h4A, 1, 0, 6'd2, 16'd2);
      @(negedge clock);
      check("post_reset_op2", 8'h3F, 1, 0, 6'd3, 16'd3);
      @(negedge clock);
      check("post_reset_done", 8'h00, 0, 1, 6'd3, 16'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conc_stim_player.md
# conc_stim_player

Synthesizable opcode stimulus sequencer that sits directly upstream of the b11 design under test and drives its `x_in`, `stbi` and `__obs` inputs. A host loads a short opcode program into an internal RAM and starts playback. The block then issues one opcode per clock: bit 7 drives `obs`, bit 6 drives `stbi`, bits 5:0 drive `x_in`. It supports single-shot and looping playback, halt, and an issued-opcode count, so concolic test sequences can be replayed on hardware without a behavioural bench.

## Interface
- `DEPTH`, 16: opcode RAM entries.
- `AW`, 4: RAM address width; must satisfy 2^AW >= DEPTH.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state except RAM contents.
- `wr_en` in 1: RAM write strobe.
- `wr_addr` in AW: RAM write address.
- `wr_data` in 8: opcode to write.
- `prog_len` in AW+1: number of valid opcodes, sampled on start.
- `start` in 1: begin playback (level sampled per cycle).
- `halt` in 1: abort playback.
- `loop_en` in 1: wrap to entry 0 at end of program, sampled on start.
- `x_in` out 6: opcode bits 5:0 to DUT.
- `stbi` out 1: opcode bit 6 to DUT.
- `obs` out 1: opcode bit 7 to DUT observation input.
- `pc` out AW+1: index of next opcode to issue.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `issue_cnt` out 16: opcodes issued since last start, saturating.

## Operation
- States: IDLE, RUN, DONE.
- Reset value: state IDLE and `pc` = 0. `x_in`, `stbi`, `obs`, `busy`, `done` and `issue_cnt` are all 0.
- RAM is not reset. Contents survive reset.
- Writes:
  - Accepted only in IDLE or DONE.
  - Ignored in RUN.
  - Ignored when `wr_addr` >= `DEPTH`.
- Start:
  - Sampled in IDLE or DONE, and only when `halt` is 0.
  - Latches `len` = min(`prog_len`, `DEPTH`) and `loop_en`.
  - Clears `issue_cnt`.
  - If `len` = 0: go to DONE, outputs stay 0.
  - Otherwise: drive outputs from ram[0], set `pc` = 1, `issue_cnt` = 1, go to RUN.
- RUN, each cycle:
  - `halt` = 1: outputs <= 0, `pc` <= 0, go to IDLE. `issue_cnt` holds.
  - Else if `pc` < `len`: outputs <= ram[`pc`] fields, `pc` += 1, `issue_cnt` += 1 (saturating at 0xFFFF).
  - Else if loop latched: outputs <= ram[0], `pc` <= 1, `issue_cnt` += 1.
  - Else: outputs <= 0, go to DONE. `pc` holds at `len`.
- `start` during RUN is ignored.
- DONE:
  - Outputs 0, `done` = 1.
  - `start` restarts as from IDLE.
  - `halt` returns to IDLE with `pc` = 0.
- `start` and `halt` asserted in the same cycle: `halt` wins and `start` is ignored.
- A write in the same cycle as an accepted start: the write is performed. The opcode issued for ram[0] is the pre-write value.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Start sampled at edge k: the first opcode is visible after edge k, so the DUT samples it at edge k+1.
- Opcode i of a single-shot program is driven during the cycle after edge k+i.
- Outputs return to 0 after edge k+`len`.
- DONE is entered at edge k+`len`, so `done` rises `len` cycles after the start edge.
- Loop mode: back-to-back issue with no bubble. Entry `len`-1 is followed immediately by entry 0.
- Halt latency: one edge. Outputs are 0 after the edge at which `halt` is sampled.
- Reset asserted mid-RUN: outputs are 0 immediately and asynchronously. After release, the block is in IDLE.

## Test plan
- **Load and single-shot play.**
  - Stimulus: write ram[0..2] = 0x85, 0x4A, 0x3F; `prog_len` = 3; `loop_en` = 0; pulse `start`.
  - Response over the next 3 cycles:
    - {obs,stbi,x_in} = {1,0,5}, then {0,1,0x0A}, then {0,0,0x3F}.
  - Then outputs 0, `done` = 1, `issue_cnt` = 3, `pc` = 3.
- **Loop mode.**
  - Stimulus: same program with `loop_en` = 1, run for 7 cycles.
  - Response: sequence 0x85, 0x4A, 0x3F, 0x85, 0x4A, 0x3F, 0x85; `issue_cnt` = 7; `busy` stays 1.
- **Halt and priority.**
  - Stimulus: assert `halt` at the 2nd issue cycle.
  - Response: outputs 0 next cycle, state IDLE, `pc` = 0.
  - Stimulus: `start` and `halt` together in IDLE.
  - Response: remains IDLE.
- **Boundaries.**
  - `prog_len` = 0 with `start`: DONE next cycle, no opcode issued, `issue_cnt` = 0.
  - `prog_len` = 31: plays exactly 16 entries, then DONE.
  - Write to `wr_addr` = 20: no RAM change.
- **Write blocking.**
  - Stimulus: during RUN, write ram[1] = 0xFF.
  - Response: a replay after DONE still issues the old ram[1] value.
- **Async reset mid-run.**
  - Stimulus: assert `reset` between edges during RUN.
  - Response: outputs 0, `busy` 0 and `issue_cnt` 0 without waiting for a clock edge.
  - A restart after release replays the preserved RAM contents.
